// File: rtl/chunked_serial_adder.sv
// ---------------------------------------------------------------------------
// chunked_serial_adder
//   Multi-cycle WIDTH-bit adder/subtractor. Adds CHUNK bits per clock with a
//   registered carry between chunks, so the combinational carry chain is only
//   CHUNK bits long. Latency from accept to out_valid is NCHUNK cycles.
//
//   Optional feature macro: CHUNKED_ADDER_OVERFLOW_EN
//     defined   -> signed-overflow flag computed and held with the result
//     undefined -> overflow port tied to 0 (port list unchanged)
//
// Parameters
//   WIDTH      operand/result width, multiple of CHUNK
//   CHUNK      bits processed per cycle (NCHUNK = WIDTH/CHUNK >= 1)
//
// Ports
//   clk        rising-edge clock
//   rst_n      synchronous active-low reset
//   in_valid   operand set offered          in_ready  block is IDLE
//   a, b       operands                     cin       carry-in (add only)
//   sub        1: a-b (a + ~b + 1), 0: a+b+cin
//   out_valid  result held (DONE)           out_ready consumer takes result
//   sum        result                       cout      carry out of MSB
//   overflow   signed overflow (0 when feature is compiled out)
// ---------------------------------------------------------------------------
module chunked_serial_adder #(
    parameter int WIDTH = 32,
    parameter int CHUNK = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             overflow
);
    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int KW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam logic [KW-1:0] KLAST = KW'(NCHUNK - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state, state_nxt;

    // Operands held as chunk arrays so chunk k is a plain index.
    logic [NCHUNK-1:0][CHUNK-1:0] a_r;
    logic [NCHUNK-1:0][CHUNK-1:0] b_r;
    logic [NCHUNK-1:0][CHUNK-1:0] sum_r;
    logic                         carry;
    logic [KW-1:0]                k;
    logic                         cout_r;

    logic [CHUNK:0]               csum;
    logic                         last;

    // Short carry chain: one CHUNK-bit add per cycle.
    assign csum = {1'b0, a_r[k]} + {1'b0, b_r[k]} + {{CHUNK{1'b0}}, carry};
    assign last = (k == KLAST);

    // -----------------------------------------------------------------------
    // FSM
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_nxt = BUSY;
            end
            BUSY: begin
                if (last) state_nxt = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // -----------------------------------------------------------------------
    // Datapath. Subtract is folded in at capture time: b is inverted and the
    // carry seeded with 1, so BUSY only ever adds and no sub flag is needed
    // afterwards.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            a_r    <= '0;
            b_r    <= '0;
            sum_r  <= '0;
            carry  <= 1'b0;
            k      <= '0;
            cout_r <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_r   <= a;
                        b_r   <= sub ? ~b : b;
                        carry <= sub ? 1'b1 : cin;
                        k     <= '0;
                    end
                end
                BUSY: begin
                    sum_r[k] <= csum[CHUNK-1:0];
                    carry    <= csum[CHUNK];
                    k        <= last ? '0 : k + KW'(1);
                    if (last) cout_r <= csum[CHUNK];
                end
                default: ;
            endcase
        end
    end

    assign sum  = sum_r;
    assign cout = cout_r;

`ifdef CHUNKED_ADDER_OVERFLOW_EN
    // Carry into the MSB recovered from the MSB sum bit of the last chunk:
    // s = a ^ b ^ c_in  =>  c_in = a ^ b ^ s.
    logic msb_cin;
    logic ovf_r;

    assign msb_cin = a_r[k][CHUNK-1] ^ b_r[k][CHUNK-1] ^ csum[CHUNK-1];

    always_ff @(posedge clk) begin
        if (!rst_n)
            ovf_r <= 1'b0;
        else if (state == BUSY && last)
            ovf_r <= msb_cin ^ csum[CHUNK];
    end

    assign overflow = ovf_r;
`else
    assign overflow = 1'b0;
`endif

endmodule

// File: tb/tb_chunked_serial_adder.sv
// ---------------------------------------------------------------------------
// tb_chunked_serial_adder
//   Three instances (32/8, 16/16, 64/4) against an arithmetic reference
//   model. Inputs driven and outputs sampled on the falling edge.
// ---------------------------------------------------------------------------
module tb_chunked_serial_adder;

`ifdef CHUNKED_ADDER_OVERFLOW_EN
    localparam bit OVF_EN = 1'b1;
`else
    localparam bit OVF_EN = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;

    logic        iv32, ir32, vo32, or32, cin32, sub32, co32, of32;
    logic [31:0] a32, b32, s32;
    logic        iv16, ir16, vo16, or16, cin16, sub16, co16, of16;
    logic [15:0] a16, b16, s16;
    logic        iv64, ir64, vo64, or64, cin64, sub64, co64, of64;
    logic [63:0] a64, b64, s64;

    int checks = 0;
    int passes = 0;

    chunked_serial_adder #(.WIDTH(32), .CHUNK(8)) d32 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv32), .in_ready(ir32),
        .a(a32), .b(b32), .cin(cin32), .sub(sub32),
        .out_valid(vo32), .out_ready(or32), .sum(s32), .cout(co32), .overflow(of32));

    chunked_serial_adder #(.WIDTH(16), .CHUNK(16)) d16 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv16), .in_ready(ir16),
        .a(a16), .b(b16), .cin(cin16), .sub(sub16),
        .out_valid(vo16), .out_ready(or16), .sum(s16), .cout(co16), .overflow(of16));

    chunked_serial_adder #(.WIDTH(64), .CHUNK(4)) d64 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv64), .in_ready(ir64),
        .a(a64), .b(b64), .cin(cin64), .sub(sub64),
        .out_valid(vo64), .out_ready(or64), .sum(s64), .cout(co64), .overflow(of64));

    // ---------------- reference model: plain (WIDTH+1)-bit arithmetic -------
    function automatic void model(input int w, input logic [63:0] a, input logic [63:0] b,
                                  input logic cin, input logic sub,
                                  output logic [63:0] s, output logic co, output logic ov);
        logic [63:0] mask, bb;
        logic [64:0] full;
        mask = (w == 64) ? {64{1'b1}} : ((64'd1 << w) - 64'd1);
        bb   = (sub ? ~b : b) & mask;
        full = {1'b0, a & mask} + {1'b0, bb} + {64'd0, (sub ? 1'b1 : cin)};
        s    = full[63:0] & mask;
        co   = full[w];
        ov   = OVF_EN && (a[w-1] == bb[w-1]) && (s[w-1] != a[w-1]);
    endfunction

    function automatic int width_of(input int sel);
        return (sel == 0) ? 32 : (sel == 1) ? 16 : 64;
    endfunction

    function automatic int nchunk_of(input int sel);
        return (sel == 0) ? 4 : (sel == 1) ? 1 : 16;
    endfunction

    // ---------------- per-instance access --------------------------------
    function automatic logic get_ready(input int sel);
        return (sel == 0) ? ir32 : (sel == 1) ? ir16 : ir64;
    endfunction

    function automatic logic get_valid(input int sel);
        return (sel == 0) ? vo32 : (sel == 1) ? vo16 : vo64;
    endfunction

    task automatic set_in(input int sel, input logic v, input logic [63:0] a, input logic [63:0] b,
                          input logic cin, input logic sub);
        case (sel)
            0:       begin iv32 = v; a32 = a[31:0]; b32 = b[31:0]; cin32 = cin; sub32 = sub; end
            1:       begin iv16 = v; a16 = a[15:0]; b16 = b[15:0]; cin16 = cin; sub16 = sub; end
            default: begin iv64 = v; a64 = a;       b64 = b;       cin64 = cin; sub64 = sub; end
        endcase
    endtask

    task automatic set_oready(input int sel, input logic r);
        case (sel)
            0:       or32 = r;
            1:       or16 = r;
            default: or64 = r;
        endcase
    endtask

    task automatic get_out(input int sel, output logic [63:0] s, output logic co, output logic ov);
        case (sel)
            0:       begin s = {32'd0, s32}; co = co32; ov = of32; end
            1:       begin s = {48'd0, s16}; co = co16; ov = of16; end
            default: begin s = s64;          co = co64; ov = of64; end
        endcase
    endtask

    // Full transaction; called at a falling edge, returns at a falling edge.
    // lat = cycles from the accepting edge to out_valid being seen.
    task automatic run_op(input int sel, input logic [63:0] a, input logic [63:0] b,
                          input logic cin, input logic sub,
                          output logic [63:0] s, output logic co, output logic ov,
                          output int lat, output bit to);
        int n;
        to = 1'b0; lat = 0; s = '0; co = 1'b0; ov = 1'b0;
        n = 0;
        while (!get_ready(sel) && n < 50) begin @(negedge clk); n++; end
        if (!get_ready(sel)) begin to = 1'b1; return; end
        set_in(sel, 1'b1, a, b, cin, sub);
        @(posedge clk);
        @(negedge clk);
        set_in(sel, 1'b0, '0, '0, 1'b0, 1'b0);
        while (!get_valid(sel) && lat < 100) begin @(negedge clk); lat++; end
        if (!get_valid(sel)) begin to = 1'b1; return; end
        get_out(sel, s, co, ov);
        set_oready(sel, 1'b1);
        @(posedge clk);
        @(negedge clk);
        set_oready(sel, 1'b0);
    endtask

    // ---------------- tests ------------------------------------------------
    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        checks++; if (ir32 !== 1'b1) $display("FAIL reset_in_ready got=%b exp=1", ir32); else passes++;
        checks++; if (vo32 !== 1'b0) $display("FAIL reset_out_valid got=%b exp=0", vo32); else passes++;
        checks++; if (s32 !== 32'd0) $display("FAIL reset_sum got=%h exp=0", s32); else passes++;
        checks++; if (co32 !== 1'b0) $display("FAIL reset_cout got=%b exp=0", co32); else passes++;
        checks++; if (of32 !== 1'b0) $display("FAIL reset_overflow got=%b exp=0", of32); else passes++;
        checks++; if (ir16 !== 1'b1 || ir64 !== 1'b1)
            $display("FAIL reset_ready_others got=%b%b exp=11", ir16, ir64); else passes++;
    endtask

    task automatic test_directed();
        logic [31:0] ta[3]  = '{32'hFFFF_FFFF, 32'd5,         32'h7FFF_FFFF};
        logic [31:0] tb_[3] = '{32'h0000_0001, 32'd7,         32'h0000_0001};
        logic        tc[3]  = '{1'b0,          1'b1,          1'b0};
        logic        tsb[3] = '{1'b0,          1'b1,          1'b0};
        logic [31:0] es[3]  = '{32'h0000_0000, 32'hFFFF_FFFE, 32'h8000_0000};
        logic        ec[3]  = '{1'b1,          1'b0,          1'b0};
        logic        eo[3]  = '{1'b0,          1'b0,          OVF_EN};
        logic [63:0] s;
        logic        co, ov;
        int          lat;
        bit          to;
        for (int i = 0; i < 3; i++) begin
            run_op(0, {32'd0, ta[i]}, {32'd0, tb_[i]}, tc[i], tsb[i], s, co, ov, lat, to);
            checks++; if (to) $display("FAIL dir%0d_timeout", i); else passes++;
            checks++; if (s[31:0] !== es[i]) $display("FAIL dir%0d_sum got=%h exp=%h", i, s[31:0], es[i]); else passes++;
            checks++; if (co !== ec[i]) $display("FAIL dir%0d_cout got=%b exp=%b", i, co, ec[i]); else passes++;
            checks++; if (ov !== eo[i]) $display("FAIL dir%0d_overflow got=%b exp=%b", i, ov, eo[i]); else passes++;
            checks++; if (lat != 4) $display("FAIL dir%0d_latency got=%0d exp=4", i, lat); else passes++;
        end
    endtask

    task automatic test_backpressure();
        int n, lat;
        set_in(0, 1'b1, 64'h1234_5678, 64'h0F0F_0F0F, 1'b0, 1'b0);
        @(posedge clk);
        @(negedge clk);
        // New operands offered the whole time the first result is pending.
        set_in(0, 1'b1, 64'd1, 64'd2, 1'b0, 1'b0);
        n = 0;
        while (!vo32 && n < 50) begin @(negedge clk); n++; end
        checks++; if (!vo32) $display("FAIL bp_first_valid_timeout"); else passes++;
        for (int c = 0; c < 10; c++) begin
            checks++; if (s32 !== 32'h2143_6587) $display("FAIL bp_hold_sum c=%0d got=%h exp=21436587", c, s32); else passes++;
            checks++; if (ir32 !== 1'b0) $display("FAIL bp_in_ready c=%0d got=%b exp=0", c, ir32); else passes++;
            checks++; if (vo32 !== 1'b1) $display("FAIL bp_out_valid c=%0d got=%b exp=1", c, vo32); else passes++;
            @(negedge clk);
        end
        or32 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        or32 = 1'b0;
        checks++; if (vo32 !== 1'b0 || ir32 !== 1'b1)
            $display("FAIL bp_after_handshake got valid=%b ready=%b exp valid=0 ready=1", vo32, ir32); else passes++;
        @(posedge clk);
        @(negedge clk);
        set_in(0, 1'b0, '0, '0, 1'b0, 1'b0);
        checks++; if (ir32 !== 1'b0) $display("FAIL bp_second_accept got=%b exp=0", ir32); else passes++;
        lat = 0;
        while (!vo32 && lat < 50) begin @(negedge clk); lat++; end
        checks++; if (lat != 4) $display("FAIL bp_second_latency got=%0d exp=4", lat); else passes++;
        checks++; if (s32 !== 32'd3) $display("FAIL bp_second_sum got=%h exp=3", s32); else passes++;
        or32 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        or32 = 1'b0;
    endtask

    task automatic test_reset_mid();
        logic [63:0] s;
        logic        co, ov;
        int          lat;
        bit          to;
        set_in(0, 1'b1, 64'hDEAD_BEEF, 64'h0101_0101, 1'b1, 1'b0);
        @(posedge clk);
        @(negedge clk);
        set_in(0, 1'b0, '0, '0, 1'b0, 1'b0);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;            // second BUSY cycle
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        checks++; if (vo32 !== 1'b0) $display("FAIL midrst_out_valid got=%b exp=0", vo32); else passes++;
        checks++; if (ir32 !== 1'b1) $display("FAIL midrst_in_ready got=%b exp=1", ir32); else passes++;
        checks++; if (s32 !== 32'd0) $display("FAIL midrst_sum got=%h exp=0", s32); else passes++;
        run_op(0, 64'd3, 64'd4, 1'b0, 1'b0, s, co, ov, lat, to);
        checks++; if (to || s[31:0] !== 32'd7) $display("FAIL midrst_fresh_sum got=%h exp=7 timeout=%b", s[31:0], to); else passes++;
        checks++; if (lat != 4) $display("FAIL midrst_fresh_latency got=%0d exp=4", lat); else passes++;
    endtask

    task automatic test_random(input int sel, input int nops);
        logic [63:0] a, b, s, es;
        logic        cin, sub, co, ec, ov, eo;
        int          lat, w, nck, bad;
        bit          to;
        w = width_of(sel); nck = nchunk_of(sel); bad = 0;
        for (int i = 0; i < nops; i++) begin
            a   = {$urandom, $urandom};
            b   = {$urandom, $urandom};
            if ($urandom_range(0, 7) == 0) a = '1;   // bias toward long carries
            cin = 1'($urandom_range(0, 1));
            sub = 1'($urandom_range(0, 1));
            model(w, a, b, cin, sub, es, ec, eo);
            run_op(sel, a, b, cin, sub, s, co, ov, lat, to);
            checks++;
            if (to) begin
                $display("FAIL rand_w%0d_timeout op=%0d", w, i);
                bad++;
                if (bad > 5) break;
                continue;
            end else passes++;
            checks++; if (s !== es) $display("FAIL rand_w%0d_sum op=%0d got=%h exp=%h", w, i, s, es); else passes++;
            checks++; if (co !== ec) $display("FAIL rand_w%0d_cout op=%0d got=%b exp=%b", w, i, co, ec); else passes++;
            checks++; if (ov !== eo) $display("FAIL rand_w%0d_overflow op=%0d got=%b exp=%b", w, i, ov, eo); else passes++;
            checks++; if (lat != nck) $display("FAIL rand_w%0d_latency op=%0d got=%0d exp=%0d", w, i, lat, nck); else passes++;
        end
    endtask

    task automatic test_back_to_back();
        int          acc[$];
        logic [31:0] exp_q[$];
        logic [63:0] a, b, es;
        logic        ec, eo;
        logic [31:0] e;
        or32 = 1'b1;
        for (int c = 0; c < 60; c++) begin
            if (vo32) begin
                e = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hxxxx_xxxx;
                checks++; if (s32 !== e) $display("FAIL b2b_sum cyc=%0d got=%h exp=%h", c, s32, e); else passes++;
            end
            if (ir32) begin
                acc.push_back(c);
                a = {32'd0, $urandom};
                b = {32'd0, $urandom};
                model(32, a, b, 1'b0, 1'b0, es, ec, eo);
                exp_q.push_back(es[31:0]);
                set_in(0, 1'b1, a, b, 1'b0, 1'b0);
            end
            @(negedge clk);
        end
        set_in(0, 1'b0, '0, '0, 1'b0, 1'b0);
        for (int c = 0; c < 20 && exp_q.size() > 0; c++) begin
            if (vo32) begin
                e = exp_q.pop_front();
                checks++; if (s32 !== e) $display("FAIL b2b_drain_sum got=%h exp=%h", s32, e); else passes++;
            end
            @(negedge clk);
        end
        or32 = 1'b0;
        checks++; if (exp_q.size() != 0) $display("FAIL b2b_drain left=%0d exp=0", exp_q.size()); else passes++;
        checks++; if (acc.size() < 5) $display("FAIL b2b_accepts got=%0d exp>=5", acc.size()); else passes++;
        for (int i = 0; i + 1 < acc.size(); i++) begin
            checks++; if (acc[i+1] - acc[i] != 6)
                $display("FAIL b2b_interval i=%0d got=%0d exp=6", i, acc[i+1] - acc[i]); else passes++;
        end
    endtask

    initial begin
        rst_n = 1'b0;
        iv32 = 0; or32 = 0; a32 = '0; b32 = '0; cin32 = 0; sub32 = 0;
        iv16 = 0; or16 = 0; a16 = '0; b16 = '0; cin16 = 0; sub16 = 0;
        iv64 = 0; or64 = 0; a64 = '0; b64 = '0; cin64 = 0; sub64 = 0;
        @(negedge clk);
        test_reset();
        test_directed();
        test_backpressure();
        test_reset_mid();
        test_random(1, 1000);
        test_random(2, 1000);
        test_random(0, 200);
        test_back_to_back();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
